// File: rtl/rate_meter.sv
// rate_meter: counts rising edges of an asynchronous signal over a gate
// window of enabled clk cycles and reports a saturated per-window rate.
module rate_meter #(
   parameter int unsigned GATE_CYCLES = 4194304,
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sig_in,
   input  logic             enable,
   output logic [WIDTH-1:0] rate,
   output logic             rate_valid,
   output logic             overflow
);

   localparam int unsigned GW = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q;
   logic [GW-1:0]          gate_q, gate_d;
   logic [WIDTH-1:0]       cnt_q, cnt_d;
   logic                   wovf_q, wovf_d;
   logic [WIDTH-1:0]       rate_q, rate_d;
   logic                   valid_q, valid_d;
   logic                   ovf_q, ovf_d;

   logic                   edge_det;
   logic                   terminal;
   logic                   cnt_full;
   logic                   cnt_hit;
   logic [WIDTH-1:0]       cnt_sat;
   logic                   ovf_now;

   assign sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
   assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign terminal = enable & (gate_q == GATE_LAST);
   assign cnt_full = (cnt_q == CNT_MAX);
   assign cnt_hit  = enable & edge_det;
   assign cnt_sat  = (cnt_hit & ~cnt_full) ? cnt_q + 1'b1 : cnt_q;
   // A terminal-cycle edge belongs to the closing window, so fold it in.
   assign ovf_now  = wovf_q | (cnt_hit & cnt_full);

   always_comb begin
      gate_d  = gate_q;
      cnt_d   = cnt_q;
      wovf_d  = wovf_q;
      rate_d  = rate_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      if (terminal) begin
         gate_d  = '0;
         cnt_d   = '0;
         wovf_d  = 1'b0;
         rate_d  = cnt_sat;
         ovf_d   = ovf_now;
         valid_d = 1'b1;
      end else if (enable) begin
         gate_d  = gate_q + 1'b1;
         cnt_d   = cnt_sat;
         wovf_d  = ovf_now;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         gate_q  <= '0;
         cnt_q   <= '0;
         wovf_q  <= 1'b0;
         rate_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= sync_q[SYNC_STAGES-1];
         gate_q  <= gate_d;
         cnt_q   <= cnt_d;
         wovf_q  <= wovf_d;
         rate_q  <= rate_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign rate       = rate_q;
   assign rate_valid = valid_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_rate_meter.sv
// tb_rate_meter: directed and random stimulus on two rate_meter instances
// (16- and 64-cycle gates), checked against a window-level model.
module tb_rate_meter;

   localparam int SYNC = 2;
   localparam int MAXV = 15;

   logic       clk;
   logic       reset;
   logic       sig_in;
   logic       enable;
   logic [3:0] rt [2];
   logic       rv [2];
   logic       ov [2];

   int vectors, errs, cyc, ph;
   bit hist [0:SYNC];
   int g [2];
   int c [2];
   int er [2];
   int eo [2];
   int ev [2];

   rate_meter #(.GATE_CYCLES(16), .WIDTH(4), .SYNC_STAGES(SYNC)) u0 (
      .clk(clk), .reset(reset), .sig_in(sig_in), .enable(enable),
      .rate(rt[0]), .rate_valid(rv[0]), .overflow(ov[0])
   );

   rate_meter #(.GATE_CYCLES(64), .WIDTH(4), .SYNC_STAGES(SYNC)) u1 (
      .clk(clk), .reset(reset), .sig_in(sig_in), .enable(enable),
      .rate(rt[1]), .rate_valid(rv[1]), .overflow(ov[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   function automatic int gate_len(input int i);
      return (i == 0) ? 16 : 64;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, compare all outputs.
   task automatic step(input bit rst, input bit en, input bit s);
      bit e;
      reset  = rst;
      enable = en;
      sig_in = s;
      @(posedge clk);
      #1;
      cyc++;
      ph++;
      e = hist[SYNC-1] & ~hist[SYNC];
      if (rst) begin
         for (int k = 0; k <= SYNC; k++) hist[k] = 1'b0;
      end else begin
         for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = s;
      end
      for (int i = 0; i < 2; i++) begin
         ev[i] = 0;
         if (rst) begin
            g[i] = 0; c[i] = 0; er[i] = 0; eo[i] = 0;
         end else if (en) begin
            c[i] += int'(e);
            if (g[i] == gate_len(i) - 1) begin
               er[i] = (c[i] > MAXV) ? MAXV : c[i];
               eo[i] = (c[i] > MAXV) ? 1 : 0;
               ev[i] = 1;
               c[i]  = 0;
               g[i]  = 0;
            end else begin
               g[i]++;
            end
         end
      end
      chk("rate0", rt[0], er[0]);
      chk("ovf0", ov[0], eo[0]);
      chk("valid0", rv[0], ev[0]);
      chk("rate1", rt[1], er[1]);
      chk("ovf1", ov[1], eo[1]);
      chk("valid1", rv[1], ev[1]);
   endtask

   initial begin
      int np, last, guard;
      vectors = 0; errs = 0; cyc = 0; ph = 0;
      for (int k = 0; k <= SYNC; k++) hist[k] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         g[i] = 0; c[i] = 0; er[i] = 0; eo[i] = 0; ev[i] = 0;
      end
      reset = 1'b1; enable = 1'b0; sig_in = 1'b0;

      // reset held with sig_in toggling
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, k[0]);
         chk("rst_rate", rt[0], 0);
         chk("rst_valid", rv[0], 0);
         chk("rst_ovf", ov[0], 0);
      end
      step(1'b0, 1'b1, 1'b1);
      chk("post_rst_valid", rv[0], 0);
      chk("post_rst_rate", rt[0], 0);

      // period-4 signal: 4 edges per 16-cycle window
      np = 0; last = 0;
      for (int k = 0; k < 64; k++) begin
         step(1'b0, 1'b1, (ph % 4) < 2);
         if (ev[0] != 0) begin
            if (np > 0) begin
               chk("p4_rate", rt[0], 4);
               chk("p4_ovf", ov[0], 0);
               chk("p4_gap", cyc - last, 16);
            end
            np++; last = cyc;
         end
      end

      // idle signal: zero rate but pulses continue
      np = 0;
      for (int k = 0; k < 48; k++) begin
         step(1'b0, 1'b1, 1'b0);
         if (ev[0] != 0) begin
            if (np > 0) begin
               chk("idle_rate", rt[0], 0);
               chk("idle_gap", cyc - last, 16);
            end
            np++; last = cyc;
         end
      end

      // period-2 signal saturates the 64-cycle instance
      np = 0;
      for (int k = 0; k < 256; k++) begin
         step(1'b0, 1'b1, ph[0]);
         if (ev[1] != 0) begin
            if (np > 0) begin
               chk("sat_rate", rt[1], 15);
               chk("sat_ovf", ov[1], 1);
            end
            np++;
         end
      end
      np = 0;
      for (int k = 0; k < 192; k++) begin
         step(1'b0, 1'b1, 1'b0);
         if (ev[1] != 0) begin
            if (np > 0) begin
               chk("unsat_rate", rt[1], 0);
               chk("unsat_ovf", ov[1], 0);
            end
            np++;
         end
      end

      // 10-cycle disable inside a window stretches it to 26 cycles
      guard = 0;
      do begin
         step(1'b0, 1'b1, (ph % 4) < 2);
         guard++;
      end while (ev[0] == 0 && guard < 20);
      chk("dis_align", ev[0], 1);
      for (int k = 1; k <= 26; k++) begin
         step(1'b0, !(k > 8 && k <= 18), (ph % 4) < 2);
         if (k < 26) chk("dis_early", rv[0], 0);
      end
      chk("dis_valid", rv[0], 1);
      chk("dis_rate", rt[0], 4);
      chk("dis_ovf", ov[0], 0);

      // reset at gate count 9, then one edge in the terminal cycle
      guard = 0;
      while (g[0] != 9 && guard < 20) begin
         step(1'b0, 1'b1, (ph % 4) < 2);
         guard++;
      end
      chk("r_align", g[0], 9);
      step(1'b1, 1'b1, 1'b0);
      chk("r_rate", rt[0], 0);
      chk("r_valid", rv[0], 0);
      for (int j = 1; j <= 16; j++) begin
         step(1'b0, 1'b1, j >= 14);
         if (j < 16) chk("r_early", rv[0], 0);
      end
      chk("r_valid17", rv[0], 1);
      chk("r_rate1", rt[0], 1);

      // random signal, enable gaps and occasional resets
      for (int k = 0; k < 400; k++) begin
         step(($urandom % 150) == 0, ($urandom % 8) != 0, $urandom % 2 == 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
